// File: rtl/branch_pkg.sv
// Shared definitions for the branch prediction unit: branch-type codes,
// adder source-select encodings and the counter reset value.
package branch_pkg;

  // Branch-type codes carried on res_branch
  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_RSVD = 3'b011;  // behaves exactly like BR_NONE
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  // Next-PC adder operand selection: a_imm picks imm over 4, b_rs1 picks rs1 over PC
  typedef struct packed {
    logic a_imm;
    logic b_rs1;
  } src_sel_t;

  localparam src_sel_t SRC_SEQ   = '{a_imm: 1'b0, b_rs1: 1'b0};  // PC + 4
  localparam src_sel_t SRC_PCREL = '{a_imm: 1'b1, b_rs1: 1'b0};  // PC + imm
  localparam src_sel_t SRC_REG   = '{a_imm: 1'b1, b_rs1: 1'b1};  // rs1 + imm

  // Widest counter the reset-value helper supports
  localparam int unsigned CNT_W_MAX = 16;

  // Weakly-not-taken value for a cnt_w-bit counter: MSB clear, all lower bits set
  function automatic logic [CNT_W_MAX-1:0] wnt_const(input int unsigned cnt_w);
    wnt_const = (16'd1 << (cnt_w - 1)) - 16'd1;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: BHT_DEPTH saturating counters, one combinational read
// port, one synchronous saturating-update write port, synchronous reset to
// weakly-not-taken. A read of an entry being written returns the old value.
module branch_bht #(
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 2,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [CNT_W-1:0] o_rd_cnt,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);
  import branch_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(wnt_const(CNT_W));

  logic [CNT_W-1:0] r_cnt [BHT_DEPTH];
  logic [CNT_W-1:0] w_old;
  logic [CNT_W-1:0] w_next;

  assign o_rd_cnt = r_cnt[i_rd_idx];
  assign w_old    = r_cnt[i_wr_idx];

  // Saturating step of the entry being trained
  always_comb begin
    w_next = w_old;
    if (i_wr_taken) begin
      if (w_old != CNT_MAX) begin
        w_next = w_old + CNT_W'(1);
      end else begin
        w_next = w_old;
      end
    end else begin
      if (w_old != CNT_MIN) begin
        w_next = w_old - CNT_W'(1);
      end else begin
        w_next = w_old;
      end
    end
  end

  // Counter storage: reset wins over a same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_cnt[i] <= CNT_WNT;
      end
    end else if (i_wr_en) begin
      r_cnt[i_wr_idx] <= w_next;
    end
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Branch prediction unit: bimodal lookup for fetch plus branch resolution
// (outcome decode, next-PC adder source select, redirect/mispredict pulses)
// and counter training. Optional performance counters are enabled by
// defining BRANCH_PERF_EN.
module branch_pred_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_taken,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic [2:0]      res_branch,
  input  logic            res_less,
  input  logic            res_zero,
  input  logic            res_pred,
  output logic            pc_a_src,
  output logic            pc_b_src,
  output logic            redirect,
  output logic            mispredict
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);
  import branch_pkg::*;

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [CNT_W-1:0] w_rd_cnt;
  logic             w_is_cond;
  logic             w_is_jump;
  logic             w_taken;
  src_sel_t         w_src;
  logic             w_mispredict;
  logic             w_redirect;
  logic             w_unused;

  logic r_pc_a_src;
  logic r_pc_b_src;
  logic r_redirect;
  logic r_mispredict;

  // Only the index bits of the PCs and the counter MSB matter
  assign w_unused = ^{lk_pc[XLEN-1:IDX_W+2], lk_pc[1:0],
                      res_pc[XLEN-1:IDX_W+2], res_pc[1:0], w_rd_cnt[CNT_W-2:0]};

  branch_bht #(
    .BHT_DEPTH (BHT_DEPTH),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (lk_pc[IDX_W+1:2]),
    .o_rd_cnt   (w_rd_cnt),
    .i_wr_en    (res_valid & w_is_cond),
    .i_wr_idx   (res_pc[IDX_W+1:2]),
    .i_wr_taken (w_taken)
  );

  assign lk_taken = w_rd_cnt[CNT_W-1];

  // Outcome decode and adder source selection for the resolving instruction
  always_comb begin
    w_is_cond = 1'b0;
    w_is_jump = 1'b0;
    w_taken   = 1'b0;
    w_src     = SRC_SEQ;
    case (res_branch)
      BR_JAL: begin
        w_is_jump = 1'b1;
        w_src     = SRC_PCREL;
      end
      BR_JALR: begin
        w_is_jump = 1'b1;
        w_src     = SRC_REG;
      end
      BR_BEQ: begin
        w_is_cond = 1'b1;
        w_taken   = res_zero;
        w_src     = res_zero ? SRC_PCREL : SRC_SEQ;
      end
      BR_BNE: begin
        w_is_cond = 1'b1;
        w_taken   = ~res_zero;
        w_src     = (~res_zero) ? SRC_PCREL : SRC_SEQ;
      end
      BR_BLT: begin
        w_is_cond = 1'b1;
        w_taken   = res_less;
        w_src     = res_less ? SRC_PCREL : SRC_SEQ;
      end
      BR_BGE: begin
        w_is_cond = 1'b1;
        w_taken   = ~res_less;
        w_src     = (~res_less) ? SRC_PCREL : SRC_SEQ;
      end
      default: begin
        // BR_NONE and BR_RSVD: sequential fetch, no training
        w_src = SRC_SEQ;
      end
    endcase
  end

  assign w_mispredict = res_valid & w_is_cond & (w_taken != res_pred);
  assign w_redirect   = w_mispredict | (res_valid & w_is_jump);

  // Registered resolve outputs: pulses last one cycle, zero without a resolve
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_a_src   <= 1'b0;
      r_pc_b_src   <= 1'b0;
      r_redirect   <= 1'b0;
      r_mispredict <= 1'b0;
    end else if (res_valid) begin
      r_pc_a_src   <= w_src.a_imm;
      r_pc_b_src   <= w_src.b_rs1;
      r_redirect   <= w_redirect;
      r_mispredict <= w_mispredict;
    end else begin
      r_pc_a_src   <= 1'b0;
      r_pc_b_src   <= 1'b0;
      r_redirect   <= 1'b0;
      r_mispredict <= 1'b0;
    end
  end

  assign pc_a_src   = r_pc_a_src;
  assign pc_b_src   = r_pc_b_src;
  assign redirect   = r_redirect;
  assign mispredict = r_mispredict;

`ifdef BRANCH_PERF_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispredicts;

  // Saturating counts of conditional resolves and mispredict pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_branches    <= 32'd0;
      r_perf_mispredicts <= 32'd0;
    end else begin
      if (res_valid && w_is_cond && (r_perf_branches != 32'hFFFF_FFFF)) begin
        r_perf_branches <= r_perf_branches + 32'd1;
      end else begin
        r_perf_branches <= r_perf_branches;
      end
      if (w_mispredict && (r_perf_mispredicts != 32'hFFFF_FFFF)) begin
        r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
      end else begin
        r_perf_mispredicts <= r_perf_mispredicts;
      end
    end
  end

  assign perf_branches    = r_perf_branches;
  assign perf_mispredicts = r_perf_mispredicts;
`endif

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit (default parameters, perf counters
// disabled): directed scenarios with literal expectations, then randomized
// resolves checked every cycle against a behavioural model.
module tb_branch_pred_unit;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lk_pc = 32'd0;
  logic        lk_taken;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = 32'd0;
  logic [2:0]  res_branch = 3'd0;
  logic        res_less = 1'b0;
  logic        res_zero = 1'b0;
  logic        res_pred = 1'b0;
  logic        pc_a_src, pc_b_src, redirect, mispredict;

  always #5 clk = ~clk;

  branch_pred_unit dut (
    .clk        (clk),
    .rst        (rst),
    .lk_pc      (lk_pc),
    .lk_taken   (lk_taken),
    .res_valid  (res_valid),
    .res_pc     (res_pc),
    .res_branch (res_branch),
    .res_less   (res_less),
    .res_zero   (res_zero),
    .res_pred   (res_pred),
    .pc_a_src   (pc_a_src),
    .pc_b_src   (pc_b_src),
    .redirect   (redirect),
    .mispredict (mispredict)
  );

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model state: counter value per table slot, expected outputs
  int   m_cnt [DEPTH];
  logic e_a = 1'b0, e_b = 1'b0, e_redir = 1'b0, e_misp = 1'b0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic bit is_cond(input logic [2:0] c);
    return c[2];
  endfunction

  function automatic bit outcome(input logic [2:0] c, input logic less, input logic zero);
    case (c)
      3'b100:         return zero;
      3'b101:         return !zero;
      3'b110:         return less;
      3'b111:         return !less;
      3'b001, 3'b010: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances on every rising edge from the sampled inputs
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_cnt[i] <= 1;
      e_a <= 1'b0; e_b <= 1'b0; e_redir <= 1'b0; e_misp <= 1'b0;
    end else if (res_valid) begin
      e_misp  <= is_cond(res_branch) && (outcome(res_branch, res_less, res_zero) != res_pred);
      e_redir <= (is_cond(res_branch) && (outcome(res_branch, res_less, res_zero) != res_pred))
                 || res_branch == 3'b001 || res_branch == 3'b010;
      e_a     <= res_branch == 3'b001 || res_branch == 3'b010
                 || (is_cond(res_branch) && outcome(res_branch, res_less, res_zero));
      e_b     <= res_branch == 3'b010;
      if (is_cond(res_branch)) begin
        if (outcome(res_branch, res_less, res_zero))
          m_cnt[idx_of(res_pc)] <= (m_cnt[idx_of(res_pc)] >= 3) ? 3 : m_cnt[idx_of(res_pc)] + 1;
        else
          m_cnt[idx_of(res_pc)] <= (m_cnt[idx_of(res_pc)] <= 0) ? 0 : m_cnt[idx_of(res_pc)] - 1;
      end
    end else begin
      e_a <= 1'b0; e_b <= 1'b0; e_redir <= 1'b0; e_misp <= 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc_a_src",   pc_a_src,   e_a);
      check("pc_b_src",   pc_b_src,   e_b);
      check("redirect",   redirect,   e_redir);
      check("mispredict", mispredict, e_misp);
      check("lk_taken",   lk_taken,   m_cnt[idx_of(lk_pc)] >= 2);
    end
  end

  // Apply one cycle of inputs shortly after the falling edge
  task automatic cyc(input logic r, input logic v, input logic [31:0] pc, input logic [2:0] br,
                     input logic less, input logic zero, input logic pred, input logic [31:0] lk);
    @(negedge clk);
    #1;
    rst = r; res_valid = v; res_pc = pc; res_branch = br;
    res_less = less; res_zero = zero; res_pred = pred; lk_pc = lk;
    #1;
  endtask

  // Literal check of the four registered outputs
  task automatic outs(input string name, input logic a, input logic b, input logic rd, input logic mp);
    check({name, ".a"},   pc_a_src,   a);
    check({name, ".b"},   pc_b_src,   b);
    check({name, ".red"}, redirect,   rd);
    check({name, ".mis"}, mispredict, mp);
  endtask

  initial begin
    logic [31:0] pc, lk;
    int ix;

    // Reset, then idle lookup
    cyc(1'b1, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0);
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h8000_0000);
    outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.lk", lk_taken, 1'b0);

    // Two beq taken with pred=0
    cyc(1'b0, 1'b1, 32'h8000_0010, 3'b100, 1'b0, 1'b1, 1'b0, 32'h8000_0010);
    check("beq0.lk", lk_taken, 1'b0);
    cyc(1'b0, 1'b1, 32'h8000_0010, 3'b100, 1'b0, 1'b1, 1'b0, 32'h8000_0010);
    outs("beq1", 1'b1, 1'b0, 1'b1, 1'b1);
    check("beq1.lk", lk_taken, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h8000_0010);
    outs("beq2", 1'b1, 1'b0, 1'b1, 1'b1);
    check("beq2.lk", lk_taken, 1'b1);
    check("beq2.cnt", m_cnt[4], 32'd3);

    // jalr: unconditional, counter untouched
    cyc(1'b0, 1'b1, 32'h8000_0020, 3'b010, 1'b0, 1'b0, 1'b0, 32'h8000_0020);
    cyc(1'b0, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h8000_0020);
    outs("jalr", 1'b1, 1'b1, 1'b1, 1'b0);
    check("jalr.lk", lk_taken, 1'b0);
    check("jalr.cnt", m_cnt[8], 32'd1);

    // bge walk: taken once, then not-taken until saturated at 0
    cyc(1'b0, 1'b1, 32'h8000_0040, 3'b111, 1'b0, 1'b0, 1'b0, 32'h8000_0040);
    cyc(1'b0, 1'b1, 32'h8000_0040, 3'b111, 1'b1, 1'b0, 1'b1, 32'h8000_0040);
    check("bge1.lk", lk_taken, 1'b1);
    check("bge1.cnt", m_cnt[16], 32'd2);
    cyc(1'b0, 1'b1, 32'h8000_0040, 3'b111, 1'b1, 1'b0, 1'b1, 32'h8000_0040);
    check("bge2.lk", lk_taken, 1'b0);
    check("bge2.cnt", m_cnt[16], 32'd1);
    cyc(1'b0, 1'b1, 32'h8000_0040, 3'b111, 1'b1, 1'b0, 1'b0, 32'h8000_0040);
    check("bge3.cnt", m_cnt[16], 32'd0);
    cyc(1'b0, 1'b1, 32'h8000_0040, 3'b111, 1'b1, 1'b0, 1'b0, 32'h8000_0040);
    check("bge4.cnt", m_cnt[16], 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h8000_0040);
    check("bge5.cnt", m_cnt[16], 32'd0);
    check("bge5.lk", lk_taken, 1'b0);

    // Resolve coinciding with reset is dropped
    cyc(1'b1, 1'b1, 32'h8000_0080, 3'b110, 1'b1, 1'b0, 1'b0, 32'h8000_0080);
    cyc(1'b0, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h8000_0080);
    outs("rstres", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rstres.lk", lk_taken, 1'b0);
    check("rstres.cnt", m_cnt[32], 32'd1);

    // Same-cycle lookup and update: old value now, new value next cycle
    cyc(1'b0, 1'b1, 32'h8000_0104, 3'b100, 1'b0, 1'b1, 1'b0, 32'h8000_0104);
    check("byp.old", lk_taken, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h8000_0104);
    check("byp.new", lk_taken, 1'b1);

    // Randomized back-to-back traffic over a few aliasing slots
    for (int n = 0; n < 600; n++) begin
      ix = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 7));
      pc = ($urandom_range(0, 1) == 1 ? 32'h8000_0000 : 32'h0040_0000)
           | (32'(ix) << 2) | 32'($urandom_range(0, 3));
      lk = ($urandom_range(0, 3) == 0) ? pc
           : (32'h8000_0000 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 8));
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), pc,
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), lk);
    end
    cyc(1'b0, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h8000_0000);
    cyc(1'b0, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h8000_0004);
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_pred_unit.md
BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL have parameter BHT_DEPTH, default 64, number of history entries; power of two, 2..1024.
REQ-003 SHALL have parameter CNT_W, default 2, saturating-counter width; taken when counter MSB=1.
REQ-004 Ports, in order:
  clk  in  1  single clock; all state updates on rising edge.
  rst  in  1  synchronous, active-high reset.
  lk_pc  in  XLEN  fetch PC for prediction lookup.
  lk_taken  out  1  prediction for lk_pc, combinational from table.
  res_valid  in  1  resolve request this cycle.
  res_pc  in  XLEN  PC of the resolving instruction.
  res_branch  in  3  branch type code.
  res_less  in  1  ALU less flag.
  res_zero  in  1  ALU zero flag.
  res_pred  in  1  prediction used at fetch for this instruction.
  pc_a_src  out  1  0 = adder A takes 4, 1 = takes imm; registered.
  pc_b_src  out  1  0 = adder B takes PC, 1 = takes rs1; registered.
  redirect  out  1  one-cycle pulse: fetch must take adder result.
  mispredict  out  1  one-cycle pulse: conditional branch outcome differed from res_pred.

Function
REQ-005 Branch codes SHALL be: 000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt/bltu, 111 bge/bgeu; 011 SHALL be treated as 000.
REQ-006 Outcome: beq taken = res_zero; bne taken = !res_zero; blt taken = res_less; bge taken = !res_less; jal/jalr always taken.
REQ-007 Source selection: none -> {0,0}; jal -> {1,0}; jalr -> {1,1}; conditional taken -> {1,0}; conditional not taken -> {0,0}.
REQ-008 Latency: res_valid in cycle N SHALL produce pc_a_src, pc_b_src, redirect, mispredict in cycle N+1; without res_valid in N, all four SHALL be 0 in N+1.
REQ-009 mispredict SHALL be 1 only for conditional codes (1xx), when the outcome differs from res_pred.
REQ-010 redirect SHALL be mispredict OR code in {jal, jalr}.
REQ-011 Index SHALL be pc[IDX_W+1:2], IDX_W = log2(BHT_DEPTH); upper PC bits ignored (aliasing permitted).
REQ-012 Training SHALL occur only for valid conditional codes: taken -> counter+1, saturating at all-ones; not taken -> counter-1, saturating at 0; none/jal/jalr/011 leave the table unchanged.
REQ-013 Same-cycle lookup and update of one index SHALL return the pre-update value; the new value SHALL be visible from the next cycle (no bypass).
REQ-014 Back-to-back resolves on consecutive cycles SHALL each be applied, with no bubble.

Reset
REQ-015 rst SHALL set every counter to weakly-not-taken (MSB 0, remaining bits 1, i.e. 01 for CNT_W=2).
REQ-016 rst SHALL force pc_a_src, pc_b_src, redirect and mispredict to 0 in the following cycle.
REQ-017 rst SHALL take priority over a same-cycle res_valid, which SHALL be dropped without training.

Configuration
REQ-018 With BRANCH_PERF_EN defined, the block SHALL add outputs perf_branches and perf_mispredicts (32 bits each), counting valid conditional resolves and mispredict pulses, saturating at 0xFFFFFFFF and cleared by rst.
REQ-019 Without BRANCH_PERF_EN, those ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-020 Package branch_pkg SHALL hold the branch-code constants, the source-select encodings and the weakly-not-taken reset constant.
REQ-021 The counter table SHALL be sub-module branch_bht, with one combinational read port, one synchronous write port and a synchronous reset.
REQ-022 Outcome decode and source selection SHALL be combinational in the top, ahead of the output registers.

Verification
REQ-023 Reset, then lk_pc=0x80000000 -> lk_taken=0; all outputs 0 the cycle after rst.
REQ-024 beq at 0x80000010 with zero=1 and pred=0, for 2 resolves -> each gives {1,0}, mispredict=1, redirect=1; lk_taken for 0x80000010 reads 1 after the first resolve and stays 1 (counter 11).
REQ-025 jalr with res_pred=0 -> next cycle {1,1}, redirect=1, mispredict=0, counter unchanged.
REQ-026 bge with less=0, then 4 bge with less=1 at the same PC -> counter walks 01->10->01->00->00 (saturates at 0).
REQ-027 res_valid together with rst on a blt taken -> no output pulse; counter stays 01.
REQ-028 Same-cycle lookup and resolve on PC 0x80000104 -> lk_taken shows the old value; the next cycle shows the new value.
